input_port_buffer: RTL

Receive-side endpoint of the router's credit-based flow control. The block stores flits arriving on one router input port in a FIFO sized to exactly the initial credit count of the upstream credit counter, presents the head flit to the switch, and returns one credit upstream for every flit the switch releases. One instance sits on each router input port, facing the upstream router's per-outport credit counter.

---
 rtl/input_port_buffer_pkg.sv | 9 +
 rtl/flit_fifo_mem.sv | 17 +
 rtl/input_port_buffer.sv | 67 ++++++
 3 files changed

// File: rtl/input_port_buffer_pkg.sv
// input_port_buffer_pkg: NoC-wide flit/credit widths and the buffer depth derived from the credit width
package input_port_buffer_pkg;
  localparam int FLIT_W = 32;
  localparam int CRED_W = 4;
  function automatic int depth_of(input int b);
    return (1 << b) - 1;
  endfunction
  localparam int DEPTH = depth_of(CRED_W);
endpackage

// File: rtl/flit_fifo_mem.sv
// flit_fifo_mem: DxW flit storage, synchronous write, asynchronous read, contents not reset
module flit_fifo_mem #(
  parameter int W  = 32,
  parameter int D  = 15,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [D];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/input_port_buffer.sv
// input_port_buffer: credit-returning input FIFO whose depth equals the upstream reset credit count
module input_port_buffer
  import input_port_buffer_pkg::*;
#(
  parameter int W = FLIT_W,
  parameter int B = CRED_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] flit_in,
  input  logic         flit_in_valid,
  output logic [W-1:0] flit_out,
  output logic         flit_out_valid,
  input  logic         flit_rel,
  output logic         credit_out,
  output logic [B-1:0] occupancy,
  output logic         overflow_err
);
  localparam int D = depth_of(B);
  localparam logic [B-1:0] LAST = B'(D - 1);
  localparam logic [B-1:0] FULL = B'(D);
  logic [B-1:0] wr_q, wr_d, rd_q, rd_d, occ_q, occ_d;
  logic cred_q, ovf_q, ovf_d, push, pop, full;
  always_comb begin
    full  = occ_q == FULL;
    pop   = flit_rel && occ_q != '0;
    // a simultaneous pop frees the slot the new flit lands in, so full does not block it
    push  = flit_in_valid && (!full || pop);
    wr_d  = push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
    occ_d = occ_q + B'(push) - B'(pop);
    ovf_d = ovf_q | (flit_in_valid & ~push);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      cred_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
      cred_q <= pop;
      ovf_q  <= ovf_d;
    end
  end
  flit_fifo_mem #(.W(W), .D(D), .AW(B)) u_mem (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_q),
    .wdata_i(flit_in),
    .raddr_i(rd_q),
    .rdata_o(flit_out)
  );
  assign flit_out_valid = occ_q != '0;
  assign credit_out     = cred_q;
  assign occupancy      = occ_q;
  assign overflow_err   = ovf_q;
`ifdef debug
  always @(posedge clk) begin
    if (rst_n && flit_in_valid && !push) $display("input_port_buffer: overflow, flit %h dropped", flit_in);
    if (rst_n && flit_rel && occ_q == '0) $display("input_port_buffer: flit_rel ignored while empty");
  end
`endif
endmodule
